// File: rtl/regfile_write_port.sv
// Write side of the 32x32 register file: two-stage write pipeline plus sweep clear.
// Define REGFILE_FWD_EN to overlay the staged write onto Regs one edge early.
module regfile_write_port #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   RegWrite,
  input  logic [AW-1:0]          WriteRegister,
  input  logic [WIDTH-1:0]       WriteData,
  output logic                   WriteReady,
  input  logic                   Clear,
  output logic                   ClearDone,
  output logic [WIDTH*DEPTH-1:0] Regs
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [0:0]                   state_q, state_d;
  logic [AW-1:0]                cnt_q, cnt_d;
  logic                         done_q, done_d;
  logic                         stage_valid_q, stage_valid_d;
  logic [AW-1:0]                stage_idx_q, stage_idx_d;
  logic [WIDTH-1:0]             stage_data_q, stage_data_d;
  logic [DEPTH-1:0][WIDTH-1:0]  regs_q, regs_d;
  logic [DEPTH-1:0][WIDTH-1:0]  regs_view;
  logic                         accept;

  assign WriteReady = (state_q == IDLE);
  assign ClearDone  = done_q;
  // Clear wins over a simultaneous write request
  assign accept = RegWrite & WriteReady & ~Clear;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    stage_valid_d = 1'b0;
    stage_idx_d   = stage_idx_q;
    stage_data_d  = stage_data_q;
    regs_d        = regs_q;
    if (stage_valid_q) begin
      regs_d[stage_idx_q] = stage_data_q;
    end
    if (accept) begin
      stage_valid_d = 1'b1;
      stage_idx_d   = WriteRegister;
      stage_data_d  = WriteData;
    end
    unique case (1'b1)
      (state_q == IDLE): begin
        if (Clear) begin
          state_d = SWEEP;
          cnt_d   = AW'(1);
        end
      end
      (state_q == SWEEP): begin
        regs_d[cnt_q] = '0;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      stage_valid_q <= 1'b0;
      stage_idx_q   <= '0;
      stage_data_q  <= '0;
      regs_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      stage_valid_q <= stage_valid_d;
      stage_idx_q   <= stage_idx_d;
      stage_data_q  <= stage_data_d;
      regs_q        <= regs_d;
    end
  end

  always_comb begin
    regs_view = regs_q;
`ifdef REGFILE_FWD_EN
    if (stage_valid_q && (stage_idx_q != '0)) begin
      regs_view[stage_idx_q] = stage_data_q;
    end
`else
`endif
    regs_view[0] = '0;
  end

  assign Regs = regs_view;

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed-vector bench for regfile_write_port.
// Expected values hand-computed; latency checks follow REGFILE_FWD_EN.
module tb_regfile_write_port;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          RegWrite;
  logic [4:0]    WriteRegister;
  logic [31:0]   WriteData;
  logic          WriteReady;
  logic          Clear;
  logic          ClearDone;
  logic [1023:0] Regs;

  int n_vec = 0;
  int n_err = 0;
  int lows;
  int pulses;

  regfile_write_port dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .WriteReady   (WriteReady),
    .Clear        (Clear),
    .ClearDone    (ClearDone),
    .Regs         (Regs)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rg(int k);
    return Regs[k*32 +: 32];
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [4:0] idx, logic [31:0] d);
    RegWrite      = 1'b1;
    WriteRegister = idx;
    WriteData     = d;
  endtask

  initial begin
    rst_n = 1'b0;
    RegWrite = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    Clear = 1'b0;
    #3;
    chk("rst_ready", 32'(WriteReady), 32'd1);
    chk("rst_done", 32'(ClearDone), 32'd0);
    chk("rst_regs", 32'(|Regs), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // 1: basic write latency
    wr(5, 32'hDEADBEEF);
    step();
    RegWrite = 1'b0;
`ifdef REGFILE_FWD_EN
    chk("t1_reg5_e1", rg(5), 32'hDEADBEEF);
`else
    chk("t1_reg5_e1", rg(5), 32'h0);
`endif
    step();
    chk("t1_reg5_e2", rg(5), 32'hDEADBEEF);
    chk("t1_reg4", rg(4), 32'h0);
    chk("t1_reg6", rg(6), 32'h0);

    // 2: register 0 write
    wr(0, 32'hFFFFFFFF);
    chk("t2_ready", 32'(WriteReady), 32'd1);
    step();
    RegWrite = 1'b0;
    chk("t2_reg0_e1", rg(0), 32'h0);
    step();
    step();
    chk("t2_reg0_e3", rg(0), 32'h0);

    // 3: back-to-back writes
    wr(7, 32'h1);
    step();
    wr(7, 32'h2);
    step();
`ifdef REGFILE_FWD_EN
    chk("t3_reg7_mid", rg(7), 32'h2);
`else
    chk("t3_reg7_mid", rg(7), 32'h1);
`endif
    wr(8, 32'h3);
    step();
    RegWrite = 1'b0;
    step();
    chk("t3_reg7", rg(7), 32'h2);
    chk("t3_reg8", rg(8), 32'h3);

    // 4: fill then sweep
    for (int k = 1; k < 32; k++) begin
      wr(5'(k), 32'(k));
      step();
    end
    RegWrite = 1'b0;
    step();
    chk("t4_fill1", rg(1), 32'd1);
    chk("t4_fill17", rg(17), 32'd17);
    chk("t4_fill31", rg(31), 32'd31);
    Clear = 1'b1;
    step();
    lows = 0;
    pulses = 0;
    for (int i = 0; i < 40 && !WriteReady; i++) begin
      lows++;
      if (ClearDone) pulses++;
      wr(9, 32'h99);
      Clear = 1'b1;
      step();
    end
    RegWrite = 1'b0;
    Clear = 1'b0;
    chk("t4_low_cycles", 32'(lows), 32'd31);
    chk("t4_early_done", 32'(pulses), 32'd0);
    chk("t4_done", 32'(ClearDone), 32'd1);
    chk("t4_ready", 32'(WriteReady), 32'd1);
    chk("t4_all_zero", 32'(|Regs), 32'd0);
    step();
    chk("t4_done_once", 32'(ClearDone), 32'd0);
    step();
    chk("t4_reg9", rg(9), 32'h0);

    // 5: Clear beats RegWrite
    wr(3, 32'h11);
    step();
    RegWrite = 1'b0;
    step();
    chk("t5_pre", rg(3), 32'h11);
    wr(3, 32'hAA);
    Clear = 1'b1;
    step();
    RegWrite = 1'b0;
    Clear = 1'b0;
    chk("t5_ready_low", 32'(WriteReady), 32'd0);
    for (int i = 0; i < 40 && !ClearDone; i++) step();
    chk("t5_done", 32'(ClearDone), 32'd1);
    chk("t5_reg3", rg(3), 32'h0);
    step();
    step();
    chk("t5_reg3_later", rg(3), 32'h0);

    // 6: reset mid-sweep
    wr(20, 32'h55);
    step();
    RegWrite = 1'b0;
    step();
    chk("t6_pre", rg(20), 32'h55);
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("t6_sweeping", 32'(WriteReady), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_regs", 32'(|Regs), 32'd0);
    chk("t6_rst_ready", 32'(WriteReady), 32'd1);
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (ClearDone) pulses++;
      step();
    end
    chk("t6_no_done", 32'(pulses), 32'd0);
    wr(20, 32'h77);
    step();
    RegWrite = 1'b0;
    step();
    chk("t6_reg20", rg(20), 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
